sub_wide_seq_ctrl: RTL and testbench

//  Sequencer computing a wide unsigned difference A - B (WORDS x W bits) on one
//  W-bit subtract slice, one word per clock, least-significant word first.

---
 rtl/sub_seq_pkg.sv | 13 +
 rtl/sub_16bit_borrow_slice.sv | 21 ++
 rtl/sub_wide_seq_ctrl.sv | 98 +++++++++
 tb/tb_sub_wide_seq_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sub_seq_pkg.sv
// Shared types and default geometry for the word-serial wide subtractor.
package sub_seq_pkg;

   localparam int DEF_W     = 16;
   localparam int DEF_WORDS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sub_16bit_borrow_slice.sv
// One W-bit unsigned subtract slice: {bout, d} = a - b - bin.
module sub_16bit_borrow_slice #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   // Extending by one zero bit makes the top bit of the difference the borrow-out.
   logic [W:0] diff;

   always_comb begin
      diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      d    = diff[W-1:0];
      bout = diff[W];
   end

endmodule

// File: rtl/sub_wide_seq_ctrl.sv
// Wide unsigned A - B computed one W-bit word per clock, LS word first,
// with valid/ready handshakes on the operand and result sides.
module sub_wide_seq_ctrl
   import sub_seq_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int WORDS = DEF_WORDS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W*WORDS-1:0] a,
   input  logic [W*WORDS-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W*WORDS-1:0] result,
   output logic               borrow,
   output logic               busy
);

   localparam int N     = W * WORDS;
   localparam int IDX_W = $clog2(WORDS);

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [N-1:0]       op_a;
   logic [N-1:0]       op_b;
   logic               borrow_r;
   logic [W-1:0]       slice_a;
   logic [W-1:0]       slice_b;
   logic [W-1:0]       slice_d;
   logic               slice_bout;
   logic               last_word;
   logic               accept;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign accept    = in_ready && in_valid;
   assign last_word = (idx == IDX_W'(WORDS - 1));
   assign slice_a   = op_a[idx*W +: W];
   assign slice_b   = op_b[idx*W +: W];

   sub_16bit_borrow_slice #(
      .W (W)
   ) u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .bin  (borrow_r),
      .d    (slice_d),
      .bout (slice_bout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last_word) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Words above idx keep stale data until the final word lands in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         op_a     <= '0;
         op_b     <= '0;
         borrow_r <= 1'b0;
         result   <= '0;
         borrow   <= 1'b0;
      end else if (accept) begin
         op_a     <= a;
         op_b     <= b;
         idx      <= '0;
         borrow_r <= 1'b0;
      end else if (state == RUN) begin
         result[idx*W +: W] <= slice_d;
         borrow_r           <= slice_bout;
         idx                <= idx + 1'b1;
         if (last_word) begin
            borrow <= slice_bout;
         end
      end
   end

endmodule

// File: tb/tb_sub_wide_seq_ctrl.sv
// Directed bench for sub_wide_seq_ctrl: vector table plus handshake, backpressure
// and mid-operation reset sequences.
module tb_sub_wide_seq_ctrl;

   localparam int W     = 16;
   localparam int WORDS = 4;
   localparam int N     = W * WORDS;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         borrow;
   logic         busy;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] r;
      logic         bo;
   } vec_t;

   vec_t vecs [10];

   sub_wide_seq_ctrl #(.W(W), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .borrow    (borrow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operand pair, then wait for out_valid and check latency and data.
   task automatic do_op(input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic [N-1:0] er, input logic eb);
      int lat;
      check("pre_in_ready", N'(in_ready), N'(1));
      a         = va;
      b         = vb;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("latency", N'(lat), N'(WORDS));
      check("result", result, er);
      check("borrow", N'(borrow), N'(eb));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_out_valid", N'(out_valid), N'(0));
   endtask

   initial begin
      int last_acc;
      int cyc;
      int d;
      int tmo;
      logic pre_rdy;

      vecs[0] = '{64'h0000_0000_0001_0000, 64'h1, 64'h0000_0000_0000_FFFF, 1'b0};
      vecs[1] = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[2] = '{64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h6, 1'b1};
      vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0};
      vecs[4] = '{64'h10, 64'h3, 64'hD, 1'b0};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[6] = '{64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[7] = '{64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0};
      vecs[8] = '{64'h1234, 64'h1235, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[9] = '{64'hDEAD_BEEF_0000_0000, 64'h1, 64'hDEAD_BEEE_FFFF_FFFF, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #12;
      check("rst_out_valid", N'(out_valid), N'(0));
      check("rst_result", result, '0);
      check("rst_borrow", N'(borrow), N'(0));
      rst = 1'b0;
      tick();
      check("rst_in_ready", N'(in_ready), N'(1));
      check("rst_busy", N'(busy), N'(0));

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].bo);
      end

      // Streaming: in_valid and out_ready held high.
      a         = 64'h10;
      b         = 64'h3;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      last_acc  = -1;
      cyc       = 0;
      for (int k = 0; k < 20; k++) begin
         pre_rdy = in_ready;
         tick();
         cyc++;
         if (pre_rdy) begin
            if (last_acc >= 0) check("accept_period", N'(cyc - last_acc), N'(WORDS + 2));
            last_acc = cyc;
         end
         if (last_acc >= 0) begin
            d = cyc - last_acc;
            check("stream_out_valid", N'(out_valid), N'(d == WORDS));
            if (d <= WORDS) check("stream_in_ready", N'(in_ready), N'(0));
            if (d == WORDS) check("stream_result", result, 64'hD);
         end
      end
      in_valid  = 1'b0;
      tmo = 0;
      while (!in_ready && tmo < 20) begin
         tick();
         tmo++;
      end
      out_ready = 1'b0;
      check("stream_drain", N'(in_ready), N'(1));

      // Backpressure: DONE holds while out_ready is low; new operands ignored.
      a        = 64'h0;
      b        = 64'h1;
      in_valid = 1'b1;
      tick();
      a        = 64'h1111;
      b        = 64'h0;
      tmo = 0;
      while (!out_valid && tmo < 20) begin
         tick();
         tmo++;
      end
      check("bp_reach_done", N'(out_valid), N'(1));
      for (int k = 0; k < 10; k++) begin
         tick();
         check("bp_out_valid", N'(out_valid), N'(1));
         check("bp_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
         check("bp_borrow", N'(borrow), N'(1));
         check("bp_in_ready", N'(in_ready), N'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release_ov", N'(out_valid), N'(0));
      check("bp_release_rdy", N'(in_ready), N'(1));
      tick();
      check("bp_no_second_accept", N'(busy), N'(0));

      // Reset two cycles into RUN aborts the operation.
      a        = 64'hFFFF_FFFF_FFFF_FFFF;
      b        = 64'h1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", N'(out_valid), N'(0));
      check("mid_rst_result", result, '0);
      check("mid_rst_busy", N'(busy), N'(0));
      tick();
      rst = 1'b0;
      tick();
      check("mid_rst_in_ready", N'(in_ready), N'(1));
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mid_rst_no_pulse", N'(out_valid), N'(0));
      end
      do_op(64'h10, 64'h3, 64'hD, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
